// File: rtl/rv_pipe_pkg.sv
// Shared pipeline definitions for the hazard/forwarding logic.
//  - Opcode constants for inst[6:2] (RV32I base opcode map).
//  - hz_state_e: the stall/flush controller state encoding.
//  - is_rv32i_opcode(): true for the base opcodes the pipe executes.
package rv_pipe_pkg;

    localparam logic [4:0] OPC_LOAD   = 5'b00000;
    localparam logic [4:0] OPC_STORE  = 5'b01000;
    localparam logic [4:0] OPC_BRANCH = 5'b11000;
    localparam logic [4:0] OPC_JAL    = 5'b11011;
    localparam logic [4:0] OPC_JALR   = 5'b11001;
    localparam logic [4:0] OPC_LUI    = 5'b01101;
    localparam logic [4:0] OPC_AUIPC  = 5'b00101;
    localparam logic [4:0] OPC_OP     = 5'b01100;
    localparam logic [4:0] OPC_OP_IMM = 5'b00100;
    localparam logic [4:0] OPC_SYSTEM = 5'b11100;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_e;

    function automatic logic is_rv32i_opcode(input logic [4:0] opc);
        return opc inside {OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR,
                           OPC_LUI, OPC_AUIPC, OPC_OP, OPC_OP_IMM, OPC_SYSTEM};
    endfunction

endpackage

// File: rtl/hazard_src_decode.sv
// Combinational register-usage decode for one instruction.
// Ports:
//  inst      in  32  instruction word
//  uses_rs1  out 1   instruction reads rs1 (everything but LUI/AUIPC/JAL)
//  uses_rs2  out 1   instruction reads rs2 (OP, STORE, BRANCH)
//  writes_rd out 1   instruction writes a non-zero rd
module hazard_src_decode
    import rv_pipe_pkg::*;
(
    input  logic [31:0] inst,
    output logic        uses_rs1,
    output logic        uses_rs2,
    output logic        writes_rd
);

    logic [4:0] opc;
    logic       unused_bits;

    assign opc = inst[6:2];

    // Only opcode and rd matter here; register fields are compared by the caller.
    assign unused_bits = ^{inst[31:12], inst[1:0]};

    always_comb begin
        uses_rs1  = !(opc inside {OPC_LUI, OPC_AUIPC, OPC_JAL});
        uses_rs2  = opc inside {OPC_OP, OPC_STORE, OPC_BRANCH};
        writes_rd = (inst[11:7] != 5'd0) && is_rv32i_opcode(opc)
                    && !(opc inside {OPC_STORE, OPC_BRANCH});
    end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage pipe. Resolves the hazards that
// forwarding cannot: load-use, taken branch/jump, and multi-cycle dmem.
// Optional build macro: HAZARD_PERF_EN adds saturating perf counters.
// Ports:
//  clock, reset            rising-edge clock, synchronous active-high reset
//  inst_d, inst_x          instructions in decode / execute
//  branch_taken_x          X-stage redirect
//  dmem_busy               data memory not ready, M must hold
//  stall_f/d/x/m           hold the respective stage register
//  bubble_x, bubble_w      load NOP into X / W
//  flush_d, flush_x        clear D / X to NOP
//  mem_err                 sticky dmem timeout flag
//  stall_cycles            (HAZARD_PERF_EN) cycles with stall_f=1
//  flush_events            (HAZARD_PERF_EN) cycles with flush_d=1
//
// state    | meaning
// ---------+-----------------------------------------------------------
// RUN      | normal flow; single-cycle load-use stalls handled here
// LU_STALL | extra load-use bubbles when LU_STALL_CYCLES > 1
// MEM_WAIT | pipe frozen on dmem_busy; resumes the saved state on exit
module hazard_stall_unit
    import rv_pipe_pkg::*;
#(
    parameter int LU_STALL_CYCLES = 1,
    parameter int MEM_TIMEOUT     = 64,
    parameter int CNT_W           = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] inst_d,
    input  logic [31:0] inst_x,
    input  logic        branch_taken_x,
    input  logic        dmem_busy,
    output logic        stall_f,
    output logic        stall_d,
    output logic        stall_x,
    output logic        stall_m,
    output logic        bubble_x,
    output logic        bubble_w,
    output logic        flush_d,
    output logic        flush_x,
    output logic        mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
`endif
);

    localparam int              TO_W    = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_MAX  = TO_W'(MEM_TIMEOUT - 1);
    localparam logic [1:0]      LU_LAST = 2'(LU_STALL_CYCLES - 1);

    hz_state_e       state, state_nxt, saved, saved_nxt, eff_state;
    logic [1:0]      lu_cnt, lu_nxt;
    logic [TO_W-1:0] to_cnt, to_nxt;
    logic            mem_err_nxt;

    logic uses_rs1_d, uses_rs2_d, writes_rd_d;
    logic uses_rs1_x, uses_rs2_x, writes_rd_x;
    logic load_use;
    logic unused_dec;

    hazard_src_decode u_dec_d (
        .inst      (inst_d),
        .uses_rs1  (uses_rs1_d),
        .uses_rs2  (uses_rs2_d),
        .writes_rd (writes_rd_d)
    );

    hazard_src_decode u_dec_x (
        .inst      (inst_x),
        .uses_rs1  (uses_rs1_x),
        .uses_rs2  (uses_rs2_x),
        .writes_rd (writes_rd_x)
    );

    // Only the producer side of X and the consumer side of D matter here.
    assign unused_dec = ^{uses_rs1_x, uses_rs2_x, writes_rd_d};

    // writes_rd_x already excludes rd==x0.
    assign load_use = (inst_x[6:2] == OPC_LOAD) && writes_rd_x &&
                      ((uses_rs1_d && (inst_d[19:15] == inst_x[11:7])) ||
                       (uses_rs2_d && (inst_d[24:20] == inst_x[11:7])));

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= RUN;
            saved   <= RUN;
            lu_cnt  <= 2'd0;
            to_cnt  <= '0;
            mem_err <= 1'b0;
        end else begin
            state   <= state_nxt;
            saved   <= saved_nxt;
            lu_cnt  <= lu_nxt;
            to_cnt  <= to_nxt;
            mem_err <= mem_err_nxt;
        end
    end

    always_comb begin
        stall_f   = 1'b0;
        stall_d   = 1'b0;
        stall_x   = 1'b0;
        stall_m   = 1'b0;
        bubble_x  = 1'b0;
        bubble_w  = 1'b0;
        flush_d   = 1'b0;
        flush_x   = 1'b0;
        saved_nxt = saved;
        lu_nxt    = lu_cnt;

        // Leaving MEM_WAIT re-evaluates the saved state's rules in the same cycle.
        eff_state = (state == MEM_WAIT && !dmem_busy) ? saved : state;
        state_nxt = eff_state;

        // Every busy cycle is a frozen cycle, so the timeout counter only
        // needs to know busy; it clears as soon as memory answers.
        to_nxt      = dmem_busy ? ((to_cnt == TO_MAX) ? to_cnt : to_cnt + TO_W'(1)) : '0;
        mem_err_nxt = mem_err | (dmem_busy && (to_cnt == TO_MAX));

        if (dmem_busy) begin
            stall_f  = 1'b1;
            stall_d  = 1'b1;
            stall_x  = 1'b1;
            stall_m  = 1'b1;
            bubble_w = 1'b1;
            if (state != MEM_WAIT) begin
                state_nxt = MEM_WAIT;
                saved_nxt = state;
            end
        end else begin
            case (eff_state)
                RUN: begin
                    if (branch_taken_x) begin
                        flush_d = 1'b1;
                        flush_x = 1'b1;
                    end else if (load_use) begin
                        stall_f  = 1'b1;
                        stall_d  = 1'b1;
                        bubble_x = 1'b1;
                        if (LU_STALL_CYCLES > 1) begin
                            state_nxt = LU_STALL;
                            lu_nxt    = 2'd1;
                        end
                    end
                end
                LU_STALL: begin
                    stall_f  = 1'b1;
                    stall_d  = 1'b1;
                    bubble_x = 1'b1;
                    if (lu_cnt == LU_LAST) begin
                        state_nxt = RUN;
                        lu_nxt    = 2'd0;
                    end else begin
                        lu_nxt = lu_cnt + 2'd1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end

        if (reset) begin
            stall_f  = 1'b0;
            stall_d  = 1'b0;
            stall_x  = 1'b0;
            stall_m  = 1'b0;
            bubble_x = 1'b0;
            bubble_w = 1'b0;
            flush_d  = 1'b0;
            flush_x  = 1'b0;
        end
    end

`ifdef HAZARD_PERF_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_f && (stall_cycles != '1))
                stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_d && (flush_events != '1))
                flush_events <= flush_events + CNT_W'(1);
        end
    end
`else
    localparam int unused_cnt_w = CNT_W;
`endif

endmodule

// File: tb/tb_hazard_stall_unit.sv
module tb_hazard_stall_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] inst_d = 32'h0000_0013;
    logic [31:0] inst_x = 32'h0000_0013;
    logic        branch_taken_x = 1'b0;
    logic        dmem_busy = 1'b0;

    logic a_sf, a_sd, a_sx, a_sm, a_bx, a_bw, a_fd, a_fx, a_me;
    logic b_sf, b_sd, b_sx, b_sm, b_bx, b_bw, b_fd, b_fx, b_me;
`ifdef HAZARD_PERF_EN
    logic [31:0] a_stc, a_fle, b_stc, b_fle;
`endif

    logic [8:0] a_vec, b_vec;
    assign a_vec = {a_sf, a_sd, a_sx, a_sm, a_bx, a_bw, a_fd, a_fx, a_me};
    assign b_vec = {b_sf, b_sd, b_sx, b_sm, b_bx, b_bw, b_fd, b_fx, b_me};

    // {stall_f, stall_d, stall_x, stall_m, bubble_x, bubble_w, flush_d, flush_x, mem_err}
    localparam logic [8:0] IDLE = 9'b000000000;
    localparam logic [8:0] LU   = 9'b110010000;
    localparam logic [8:0] FRZ  = 9'b111101000;
    localparam logic [8:0] FL   = 9'b000000110;
    localparam logic [8:0] ERR  = 9'b000000001;

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LUI = 7'b0110111;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    // dut_a: default parameters. dut_b: two load-use bubbles, short timeout.
    hazard_stall_unit dut_a (
        .clock(clock), .reset(reset), .inst_d(inst_d), .inst_x(inst_x),
        .branch_taken_x(branch_taken_x), .dmem_busy(dmem_busy),
        .stall_f(a_sf), .stall_d(a_sd), .stall_x(a_sx), .stall_m(a_sm),
        .bubble_x(a_bx), .bubble_w(a_bw), .flush_d(a_fd), .flush_x(a_fx),
        .mem_err(a_me)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(a_stc), .flush_events(a_fle)
`endif
    );

    hazard_stall_unit #(.LU_STALL_CYCLES(2), .MEM_TIMEOUT(4)) dut_b (
        .clock(clock), .reset(reset), .inst_d(inst_d), .inst_x(inst_x),
        .branch_taken_x(branch_taken_x), .dmem_busy(dmem_busy),
        .stall_f(b_sf), .stall_d(b_sd), .stall_x(b_sx), .stall_m(b_sm),
        .bubble_x(b_bx), .bubble_w(b_bw), .flush_d(b_fd), .flush_x(b_fx),
        .mem_err(b_me)
`ifdef HAZARD_PERF_EN
        , .stall_cycles(b_stc), .flush_events(b_fle)
`endif
    );

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'b0, rs2, rs1, 3'b010, rd, op};
    endfunction

    // Apply inputs just after a rising edge, return at the falling edge for sampling.
    task automatic cyc(input logic [31:0] x, input logic [31:0] d, input logic br,
                       input logic busy, input logic rst);
        @(posedge clock);
        #1;
        inst_x = x;
        inst_d = d;
        branch_taken_x = br;
        dmem_busy = busy;
        reset = rst;
        @(negedge clock);
    endtask

    task automatic do_reset();
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b1);
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b1);
    endtask

    task automatic test_reset();
        cyc(mk(OP_LW, 5, 1, 0), mk(OP_R, 6, 5, 2), 1'b1, 1'b1, 1'b1);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_hold got a=%b b=%b exp a=%b b=%b", a_vec, b_vec, IDLE, IDLE);
        end
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_release got a=%b b=%b exp all zero", a_vec, b_vec);
        end
    endtask

    task automatic test_load_use();
        logic [8:0] ea [3] = '{LU, IDLE, IDLE};
        logic [8:0] eb [3] = '{LU, LU, IDLE};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc((i == 0) ? mk(OP_LW, 5, 1, 0) : NOP, mk(OP_R, 6, 5, 2), 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL load_use[%0d] got a=%b b=%b exp a=%b b=%b", i, a_vec, b_vec, ea[i], eb[i]);
            end
        end
    endtask

    task automatic test_no_hazard();
        logic [31:0] xs [6];
        logic [31:0] ds [6];
        logic [8:0]  ea [6] = '{IDLE, IDLE, IDLE, LU, IDLE, LU};
        logic [8:0]  eb [6] = '{IDLE, IDLE, IDLE, LU, LU, LU};
        xs[0] = mk(OP_LW, 0, 1, 0);  ds[0] = mk(OP_R, 6, 0, 2);    // rd = x0
        xs[1] = mk(OP_LW, 5, 1, 0);  ds[1] = mk(OP_LUI, 5, 5, 0);  // lui ignores rs1 field
        xs[2] = mk(OP_R, 5, 1, 2);   ds[2] = mk(OP_R, 6, 5, 2);    // producer not a load
        xs[3] = mk(OP_LW, 5, 1, 0);  ds[3] = mk(OP_SW, 0, 3, 5);   // sw x5 -> rs2 use
        xs[4] = NOP;                 ds[4] = mk(OP_SW, 0, 3, 5);
        xs[5] = mk(OP_LW, 7, 1, 0);  ds[5] = mk(OP_BEQ, 0, 1, 7);  // beq rs2 use (b still stalling)
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cyc(xs[i], ds[i], 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL no_hazard[%0d] got a=%b b=%b exp a=%b b=%b", i, a_vec, b_vec, ea[i], eb[i]);
            end
        end
    endtask

    task automatic test_branch();
        logic [8:0] ex [4] = '{FL, IDLE, FRZ, FL};
        logic       br [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        logic       bz [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            cyc((i == 1) ? NOP : mk(OP_LW, 5, 1, 0), (i == 1) ? NOP : mk(OP_R, 6, 5, 2),
                br[i], bz[i], 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {ex[i], ex[i]}) begin
                n_err++;
                $display("FAIL branch[%0d] got a=%b b=%b exp %b", i, a_vec, b_vec, ex[i]);
            end
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if ({a_fle, b_fle} !== {32'd2, 32'd2}) begin
            n_err++;
            $display("FAIL perf_flush got a=%0d b=%0d exp 2", a_fle, b_fle);
        end
`endif
    endtask

    task automatic test_mem_busy();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            cyc(NOP, NOP, 1'b0, 1'b1, 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {FRZ, FRZ}) begin
                n_err++;
                $display("FAIL mem_busy[%0d] got a=%b b=%b exp %b", i, a_vec, b_vec, FRZ);
            end
        end
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_vec, b_vec[8:1]} !== {IDLE, IDLE[8:1]}) begin
            n_err++;
            $display("FAIL mem_busy_exit got a=%b b=%b exp idle", a_vec, b_vec);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            cyc(NOP, NOP, 1'b0, 1'b1, 1'b0);
            if (i == 3 || i == 5 || i == 10) begin
                n_vec++;
                if ({a_vec, b_vec} !== {FRZ, (i == 3) ? FRZ : (FRZ | ERR)}) begin
                    n_err++;
                    $display("FAIL timeout_busy[%0d] got a=%b b=%b", i, a_vec, b_vec);
                end
            end
        end
        for (int i = 0; i < 2; i++) begin
            cyc(NOP, NOP, 1'b0, 1'b0, 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {IDLE, ERR}) begin
                n_err++;
                $display("FAIL timeout_sticky[%0d] got a=%b b=%b exp a=%b b=%b", i, a_vec, b_vec, IDLE, ERR);
            end
        end
        do_reset();
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if (b_vec !== IDLE) begin
            n_err++;
            $display("FAIL timeout_clear got b=%b exp %b", b_vec, IDLE);
        end
    endtask

    task automatic test_lu_busy();
        logic [8:0] ea [5] = '{LU, FRZ, FRZ, IDLE, IDLE};
        logic [8:0] eb [5] = '{LU, FRZ, FRZ, LU, IDLE};
        logic       bz [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cyc((i == 0) ? mk(OP_LW, 5, 1, 0) : NOP, mk(OP_R, 6, 5, 2), 1'b0, bz[i], 1'b0);
            n_vec++;
            if ({a_vec, b_vec} !== {ea[i], eb[i]}) begin
                n_err++;
                $display("FAIL lu_busy[%0d] got a=%b b=%b exp a=%b b=%b", i, a_vec, b_vec, ea[i], eb[i]);
            end
        end
`ifdef HAZARD_PERF_EN
        n_vec++;
        if ({a_stc, b_stc} !== {32'd3, 32'd4}) begin
            n_err++;
            $display("FAIL perf_stall got a=%0d b=%0d exp a=3 b=4", a_stc, b_stc);
        end
`endif
    endtask

    task automatic test_reset_mid();
        do_reset();
        cyc(mk(OP_LW, 5, 1, 0), mk(OP_R, 6, 5, 2), 1'b0, 1'b0, 1'b0);
        cyc(NOP, mk(OP_R, 6, 5, 2), 1'b0, 1'b0, 1'b1);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_mid_stall got a=%b b=%b exp idle", a_vec, b_vec);
        end
        cyc(NOP, mk(OP_R, 6, 5, 2), 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_mid_stall_after got a=%b b=%b exp idle", a_vec, b_vec);
        end
        cyc(NOP, NOP, 1'b0, 1'b1, 1'b0);
        cyc(NOP, NOP, 1'b0, 1'b1, 1'b1);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_mid_wait got a=%b b=%b exp idle", a_vec, b_vec);
        end
        cyc(NOP, NOP, 1'b0, 1'b0, 1'b0);
        n_vec++;
        if ({a_vec, b_vec} !== {IDLE, IDLE}) begin
            n_err++;
            $display("FAIL reset_mid_wait_after got a=%b b=%b exp idle", a_vec, b_vec);
        end
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_hazard();
        test_branch();
        test_mem_busy();
        test_timeout();
        test_lu_busy();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
